// File: rtl/ula_controle_multiciclo.sv
// Multicycle MIPS-subset control FSM driving the ULA and datapath strobes; outputs are registered
// alongside the state (ir_write is combinational on mem_ready); memory states stall on mem_ready.
module ula_controle_multiciclo #(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] inputULA,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_EXEC_R  = 4'd3,
      S_ALU_WB  = 4'd4,
      S_ADDR    = 4'd5,
      S_MEM_RD  = 4'd6,
      S_MEM_WB  = 4'd7,
      S_MEM_WR  = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ADDI_WB = 4'd11
   } state_t;

   typedef struct packed {
      logic [3:0] op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
   } ctrl_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [3:0] ULA_ADD = 4'b0010;
   localparam logic [3:0] ULA_SUB = 4'b0110;
   localparam logic [3:0] ULA_AND = 4'b0000;
   localparam logic [3:0] ULA_OR  = 4'b0001;
   localparam logic [3:0] ULA_SLT = 4'b0111;

   localparam bit          TO_EN   = (MEM_TIMEOUT > 0);
   localparam logic [15:0] TO_LAST = (MEM_TIMEOUT > 0) ? 16'(MEM_TIMEOUT - 1) : 16'd0;

   // {known, op}
   function automatic logic [4:0] funct_dec(input logic [5:0] f);
      case (f)
         6'b100000: return {1'b1, ULA_ADD};
         6'b100010: return {1'b1, ULA_SUB};
         6'b100100: return {1'b1, ULA_AND};
         6'b100101: return {1'b1, ULA_OR};
         6'b101010: return {1'b1, ULA_SLT};
         default:   return {1'b0, ULA_AND};
      endcase
   endfunction

   function automatic ctrl_t decode(input state_t s, input logic [3:0] rop);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:   begin c.mem_read = 1'b1; c.src_b = 2'b01; c.op = ULA_ADD; end
         S_DECODE:  begin c.pc_write = 1'b1; c.src_a = 2'b10; c.src_b = 2'b11; c.op = ULA_ADD; end
         S_EXEC_R:  begin c.src_a = 2'b01; c.op = rop; end
         S_ALU_WB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         S_ADDR:    begin c.src_a = 2'b01; c.src_b = 2'b10; c.op = ULA_ADD; end
         // Memory states keep the address computation alive since outputULA is re-registered each cycle.
         S_MEM_RD:  begin c.src_a = 2'b01; c.src_b = 2'b10; c.op = ULA_ADD; c.i_or_d = 1'b1; c.mem_read = 1'b1; end
         S_MEM_WB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
         S_MEM_WR:  begin c.src_a = 2'b01; c.src_b = 2'b10; c.op = ULA_ADD; c.i_or_d = 1'b1; c.mem_write = 1'b1; end
         S_BRANCH:  begin c.pc_write_cond = 1'b1; c.pc_source = 2'b01; c.src_a = 2'b01; c.op = ULA_SUB; end
         S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
         S_ADDI_WB: c.reg_write = 1'b1;
         default:   c = '0;
      endcase
      return c;
   endfunction

   state_t      state_q, state_d;
   ctrl_t       ctrl_q, ctrl_d;
   logic        illegal_q, illegal_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  rfn;
   logic        waiting, timeout;

   always_comb begin
      rfn       = funct_dec(funct);
      state_d   = state_q;
      illegal_d = 1'b0;
      waiting   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
      timeout   = TO_EN && waiting && (cnt_q == TO_LAST) && !mem_ready;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:                   state_d = S_EXEC_R;
               OP_LW, OP_SW, OP_ADDI:  state_d = S_ADDR;
               OP_BEQ:                 state_d = S_BRANCH;
               OP_J:                   state_d = S_JUMP;
               default: begin state_d = S_FETCH; illegal_d = 1'b1; end
            endcase
         end
         S_EXEC_R: begin
            if (rfn[4]) state_d = S_ALU_WB;
            else begin state_d = S_FETCH; illegal_d = 1'b1; end
         end
         S_ADDR: begin
            case (opcode)
               OP_LW:   state_d = S_MEM_RD;
               OP_SW:   state_d = S_MEM_WR;
               OP_ADDI: state_d = S_ADDI_WB;
               default: begin state_d = S_FETCH; illegal_d = 1'b1; end
            endcase
         end
         S_MEM_RD: if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WR: if (mem_ready) state_d = S_FETCH;
         S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
         default: begin state_d = S_FETCH; illegal_d = 1'b1; end
      endcase
      if (timeout) begin
         state_d   = S_FETCH;
         illegal_d = 1'b1;
      end
      // A timeout re-enters S_FETCH, which must restart the count like any other state change.
      cnt_d  = (!waiting || timeout || (state_d != state_q)) ? 16'd0 : cnt_q + 16'd1;
      ctrl_d = decode(state_d, rfn[3:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= 16'd0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign inputULA      = ctrl_q.op;
   assign alu_src_a     = ctrl_q.src_a;
   assign alu_src_b     = ctrl_q.src_b;
   assign pc_write      = ctrl_q.pc_write;
   assign pc_write_cond = ctrl_q.pc_write_cond;
   assign pc_source     = ctrl_q.pc_source;
   assign i_or_d        = ctrl_q.i_or_d;
   assign mem_read      = ctrl_q.mem_read;
   assign mem_write     = ctrl_q.mem_write;
   assign reg_dst       = ctrl_q.reg_dst;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign reg_write     = ctrl_q.reg_write;
   assign ir_write      = (state_q == S_FETCH) && mem_ready;
   assign state         = state_q;
   assign illegal       = illegal_q;

endmodule

// File: doc/ula_controle_multiciclo.md
Name: ula_controle_multiciclo

Overview:
- Multicycle MIPS-subset control FSM. It is the driving end of the ULA interface: it produces the 4-bit `inputULA` code plus operand-select, memory and register-file strobes for the datapath.
- It accounts for the ULA's one-cycle registered result, so every ULA result is consumed in the state after the one that issued the operation.
- Supported instructions: R-type (add, sub, and, or, slt), lw, sw, beq, j, addi.

Parameters:
- MEM_TIMEOUT, 0, if nonzero, the number of cycles to wait for `mem_ready` before raising `illegal` and returning to S_FETCH. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26] as latched by the datapath
- funct  in  6  IR[5:0]
- zero  in  1  combinational `regA == regB` from the datapath
- mem_ready  in  1  memory accepted or returned data this cycle
- inputULA  out  4  ULA operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- alu_src_a  out  2  00 PC, 01 regA, 10 outputULA
- alu_src_b  out  2  00 regB, 01 constant 4, 10 signext(imm), 11 signext(imm)<<2
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if `zero`
- pc_source  out  2  00 outputULA, 01 outputULA (branch target), 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 outputULA
- mem_read  out  1
- mem_write  out  1
- ir_write  out  1
- reg_dst  out  1  1 rd, 0 rt
- mem_to_reg  out  1
- reg_write  out  1
- state  out  4  current state encoding
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct or a timeout

Behaviour:
- Reset (`rst_n` = 0, asynchronous): state = S_IDLE (0), all outputs = 0 immediately. A `mem_write` in progress is dropped.
- S_IDLE always goes to S_FETCH on the next clock.
- Outputs are decoded from the current state only, except `ir_write` and `pc_write_cond` as noted.
- Unlisted outputs are 0 in each state.
- State encodings and behaviour:
  - S_FETCH (1): mem_read=1, i_or_d=0; issues PC+4 (src_a=00, src_b=01, add). ir_write = mem_ready. Stays in S_FETCH until mem_ready, then goes to S_DECODE.
  - S_DECODE (2): pc_write=1, pc_source=00 (loads PC+4 held in outputULA). Issues the branch target (src_a=10, src_b=11, add). Next state:
    - R-type → S_EXEC_R
    - lw, sw, addi → S_ADDR
    - beq → S_BRANCH
    - j → S_JUMP
    - any other opcode → S_FETCH with illegal=1
  - S_EXEC_R (3): src_a=01, src_b=00, op taken from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). An unknown funct goes to S_FETCH with illegal=1 and no reg_write. Otherwise → S_ALU_WB.
  - S_ALU_WB (4): reg_dst=1, mem_to_reg=0, reg_write=1 → S_FETCH.
  - S_ADDR (5): src_a=01, src_b=10, add. Next: lw → S_MEM_RD, sw → S_MEM_WR, addi → S_ADDI_WB.
  - S_MEM_RD (6): i_or_d=1, mem_read=1; re-issues the S_ADDR operation so outputULA stays stable. Waits for mem_ready, then → S_MEM_WB.
  - S_MEM_WB (7): reg_dst=0, mem_to_reg=1, reg_write=1 → S_FETCH.
  - S_MEM_WR (8): i_or_d=1, mem_write=1; re-issues the S_ADDR operation. Waits for mem_ready, then → S_FETCH.
  - S_BRANCH (9): outputULA holds the target. pc_write_cond=1, pc_source=01; the PC loads only when zero=1. Issues sub on regA/regB. → S_FETCH.
  - S_JUMP (10): pc_write=1, pc_source=10 → S_FETCH.
  - S_ADDI_WB (11): reg_dst=0, mem_to_reg=0, reg_write=1 → S_FETCH.
- Unused encodings 12–15 go to S_FETCH with illegal=1.
- ULA latency rule: any state that uses outputULA for more than one cycle must re-issue identical `inputULA` and operand selects every cycle.
- Timeout (MEM_TIMEOUT > 0): a counter runs in S_FETCH, S_MEM_RD and S_MEM_WR and clears on every state change. When it reaches MEM_TIMEOUT: illegal=1, → S_FETCH, no write strobes.
- Instruction cycle counts with mem_ready already high: R/addi 4, lw 5, sw 4, beq 3, j 3.

Test Plan:
- Reset release, mem_ready=1, opcode 000000, funct 100010 → state sequence 1,2,3,4,1. In state 3, inputULA=0110. In state 4, reg_write=1 and reg_dst=1.
- lw (100011) with mem_ready low for 3 cycles in S_MEM_RD → 3 extra cycles in state 6, with inputULA=0010, alu_src_b=10 and i_or_d=1 held every cycle. Then state 7 with mem_to_reg=1.
- beq (000100) with zero=1, then again with zero=0 → pc_write_cond=1 and pc_source=01 in state 9 both times; the PC loads only in the first case.
- R-type with funct 101010 → inputULA=0111. funct 111111 → illegal pulse, return to state 1, reg_write stays 0.
- rst_n driven low mid S_MEM_WR → mem_write=0 and state=0 asynchronously, before the next clock edge.
- MEM_TIMEOUT=4, mem_ready held 0 in S_FETCH → illegal pulses after 4 cycles, FSM re-enters S_FETCH, ir_write never asserted.
